// File: rtl/rs_sched_pkg.sv
// rtl/rs_sched_pkg.sv - shared constants and CDB slicing helper for rs_sched
package rs_sched_pkg;

    // Opcode enum value that means "no operation" on the issue port.
    localparam int OPENUM_NOP = 0;

    // ROB tag 0 marks an operand whose value is already present.
    localparam int ZERO_ROB = 0;

    // Result buses are packed side by side: bus k sits at [k*w +: w].
    function automatic int cdb_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/rs_sched_select.sv
// rtl/rs_sched_select.sv - combinational free-slot and issue-candidate picker
//
// Ports: busy/ready entry vectors in; older age matrix in (RS_AGE_SELECT_EN only,
// older[i*DEPTH+j] = entry i was dispatched before entry j); free_idx/free_vld
// give the lowest free entry, sel_idx/sel_vld the entry to issue.
// RS_AGE_SELECT_EN: oldest ready entry wins; otherwise lowest-index ready entry.
module rs_sched_select #(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic [DEPTH-1:0]       busy,
    input  logic [DEPTH-1:0]       ready,
`ifdef RS_AGE_SELECT_EN
    input  logic [DEPTH*DEPTH-1:0] older,
`endif
    output logic [IDX_W-1:0]       free_idx,
    output logic                   free_vld,
    output logic [IDX_W-1:0]       sel_idx,
    output logic                   sel_vld
);

    // Scan high to low so the last hit, i.e. the lowest index, wins.
    always_comb begin
        free_idx = '0;
        free_vld = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_idx = IDX_W'(i);
                free_vld = 1'b1;
            end
        end
    end

`ifdef RS_AGE_SELECT_EN
    // An entry is the oldest ready one when no other ready entry is older.
    // The matrix is a strict order over busy entries, so exactly one qualifies.
    always_comb begin
        logic blocked;
        sel_idx = '0;
        sel_vld = 1'b0;
        blocked = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (ready[j] && older[j*DEPTH + i]) begin
                    blocked = 1'b1;
                end
            end
            if (ready[i] && !blocked) begin
                sel_idx = IDX_W'(i);
                sel_vld = 1'b1;
            end
        end
    end
`else
    always_comb begin
        sel_idx = '0;
        sel_vld = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_idx = IDX_W'(i);
                sel_vld = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/rs_sched.sv
// rtl/rs_sched.sv - reservation station with CDB snooping and registered single issue
//
// Ports: clk, rst (sync, active-high), flush (same effect as rst);
// dsp_* dispatch insert with full/count status; cdb_valid/cdb_rob_id/cdb_result
// snooped result buses; iss_valid/iss_ready handshake with iss_* issue register.
// Build option RS_AGE_SELECT_EN: issue the oldest ready entry via an age matrix.
module rs_sched
    import rs_sched_pkg::*;
#(
    parameter int RS_DEPTH = 16,
    parameter int CDB_N    = 2,
    parameter int DATA_W   = 32,
    parameter int ROB_ID_W = 4,
    parameter int OPENUM_W = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          dsp_valid,
    input  logic [OPENUM_W-1:0]           dsp_openum,
    input  logic [DATA_W-1:0]             dsp_V1,
    input  logic [DATA_W-1:0]             dsp_V2,
    input  logic [ROB_ID_W-1:0]           dsp_Q1,
    input  logic [ROB_ID_W-1:0]           dsp_Q2,
    input  logic [DATA_W-1:0]             dsp_pc,
    input  logic [DATA_W-1:0]             dsp_imm,
    input  logic [ROB_ID_W-1:0]           dsp_rob_id,
    output logic                          full,
    output logic [$clog2(RS_DEPTH+1)-1:0] count,
    input  logic [CDB_N-1:0]              cdb_valid,
    input  logic [CDB_N*ROB_ID_W-1:0]     cdb_rob_id,
    input  logic [CDB_N*DATA_W-1:0]       cdb_result,
    output logic                          iss_valid,
    input  logic                          iss_ready,
    output logic [OPENUM_W-1:0]           iss_openum,
    output logic [DATA_W-1:0]             iss_V1,
    output logic [DATA_W-1:0]             iss_V2,
    output logic [DATA_W-1:0]             iss_pc,
    output logic [DATA_W-1:0]             iss_imm,
    output logic [ROB_ID_W-1:0]           iss_rob_id
);

    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam int CNT_W = $clog2(RS_DEPTH + 1);
    localparam logic [ROB_ID_W-1:0] ROB_NONE = ROB_ID_W'(ZERO_ROB);
    localparam logic [OPENUM_W-1:0] OP_NOP   = OPENUM_W'(OPENUM_NOP);

    logic [RS_DEPTH-1:0] busy;
    logic [OPENUM_W-1:0] e_op  [RS_DEPTH];
    logic [DATA_W-1:0]   e_v1  [RS_DEPTH];
    logic [DATA_W-1:0]   e_v2  [RS_DEPTH];
    logic [DATA_W-1:0]   e_pc  [RS_DEPTH];
    logic [DATA_W-1:0]   e_imm [RS_DEPTH];
    logic [ROB_ID_W-1:0] e_q1  [RS_DEPTH];
    logic [ROB_ID_W-1:0] e_q2  [RS_DEPTH];
    logic [ROB_ID_W-1:0] e_rob [RS_DEPTH];
`ifdef RS_AGE_SELECT_EN
    logic [RS_DEPTH*RS_DEPTH-1:0] older;
`endif

    logic [RS_DEPTH-1:0] ready;
    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    free_idx, sel_idx;
    logic                free_vld, sel_vld;
    logic                ins_en, iss_load;
    logic [ROB_ID_W-1:0] ins_q1, ins_q2;
    logic [DATA_W-1:0]   ins_v1, ins_v2;
    logic [ROB_ID_W-1:0] wk_q1 [RS_DEPTH];
    logic [ROB_ID_W-1:0] wk_q2 [RS_DEPTH];
    logic [DATA_W-1:0]   wk_v1 [RS_DEPTH];
    logic [DATA_W-1:0]   wk_v2 [RS_DEPTH];

    // Resolve one operand against all buses; the lowest matching bus wins
    // because the scan runs downwards and the last assignment sticks.
    function automatic logic [ROB_ID_W+DATA_W-1:0] snoop(
        input logic [ROB_ID_W-1:0] q,
        input logic [DATA_W-1:0]   v
    );
        logic [ROB_ID_W+DATA_W-1:0] r;
        r = {q, v};
        for (int k = CDB_N - 1; k >= 0; k--) begin
            if (cdb_valid[k] && q != ROB_NONE &&
                cdb_rob_id[cdb_lsb(k, ROB_ID_W) +: ROB_ID_W] == q) begin
                r = {ROB_NONE, cdb_result[cdb_lsb(k, DATA_W) +: DATA_W]};
            end
        end
        return r;
    endfunction

    always_comb begin
        {ins_q1, ins_v1} = snoop(dsp_Q1, dsp_V1);
        {ins_q2, ins_v2} = snoop(dsp_Q2, dsp_V2);
        for (int i = 0; i < RS_DEPTH; i++) begin
            {wk_q1[i], wk_v1[i]} = snoop(e_q1[i], e_v1[i]);
            {wk_q2[i], wk_v2[i]} = snoop(e_q2[i], e_v2[i]);
        end
    end

    always_comb begin
        ready = '0;
        cnt   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            ready[i] = busy[i] && e_q1[i] == ROB_NONE && e_q2[i] == ROB_NONE;
            cnt      = cnt + CNT_W'(busy[i]);
        end
    end

    assign count    = cnt;
    assign full     = (cnt == CNT_W'(RS_DEPTH));
    assign ins_en   = dsp_valid && free_vld;
    assign iss_load = !iss_valid || iss_ready;

    rs_sched_select #(
        .DEPTH (RS_DEPTH),
        .IDX_W (IDX_W)
    ) u_select (
        .busy     (busy),
        .ready    (ready),
`ifdef RS_AGE_SELECT_EN
        .older    (older),
`endif
        .free_idx (free_idx),
        .free_vld (free_vld),
        .sel_idx  (sel_idx),
        .sel_vld  (sel_vld)
    );

    // Insert targets a slot that was free before the edge and issue takes a
    // slot that was ready before it, so the two never collide.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            busy       <= '0;
            iss_valid  <= 1'b0;
            iss_openum <= '0;
            iss_V1     <= '0;
            iss_V2     <= '0;
            iss_pc     <= '0;
            iss_imm    <= '0;
            iss_rob_id <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                e_q1[i] <= '0;
                e_q2[i] <= '0;
            end
`ifdef RS_AGE_SELECT_EN
            older <= '0;
`endif
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                e_q1[i] <= wk_q1[i];
                e_q2[i] <= wk_q2[i];
                e_v1[i] <= wk_v1[i];
                e_v2[i] <= wk_v2[i];
            end
            if (iss_load) begin
                if (sel_vld) begin
                    iss_valid       <= 1'b1;
                    iss_openum      <= e_op[sel_idx];
                    iss_V1          <= e_v1[sel_idx];
                    iss_V2          <= e_v2[sel_idx];
                    iss_pc          <= e_pc[sel_idx];
                    iss_imm         <= e_imm[sel_idx];
                    iss_rob_id      <= e_rob[sel_idx];
                    busy[sel_idx]   <= 1'b0;
                end else begin
                    iss_valid  <= 1'b0;
                    iss_openum <= OP_NOP;
                end
            end
            if (ins_en) begin
                busy[free_idx]  <= 1'b1;
                e_op[free_idx]  <= dsp_openum;
                e_v1[free_idx]  <= ins_v1;
                e_v2[free_idx]  <= ins_v2;
                e_q1[free_idx]  <= ins_q1;
                e_q2[free_idx]  <= ins_q2;
                e_pc[free_idx]  <= dsp_pc;
                e_imm[free_idx] <= dsp_imm;
                e_rob[free_idx] <= dsp_rob_id;
`ifdef RS_AGE_SELECT_EN
                // The newcomer is younger than every other entry; stale bits
                // in free rows are rewritten when those slots are refilled.
                for (int j = 0; j < RS_DEPTH; j++) begin
                    older[int'(free_idx)*RS_DEPTH + j] <= 1'b0;
                    if (j != int'(free_idx)) begin
                        older[j*RS_DEPTH + int'(free_idx)] <= 1'b1;
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_rs_sched.sv
// tb/tb_rs_sched.sv - randomized and directed self-checking bench for rs_sched
module tb_rs_sched;

    localparam int DEPTH  = 16;
    localparam int CDB_N  = 2;
    localparam int DW     = 32;
    localparam int RW     = 4;
    localparam int OW     = 6;

    logic              clk, rst, flush, dsp_valid, full, iss_valid, iss_ready;
    logic [OW-1:0]     dsp_openum, iss_openum;
    logic [DW-1:0]     dsp_V1, dsp_V2, dsp_pc, dsp_imm;
    logic [RW-1:0]     dsp_Q1, dsp_Q2, dsp_rob_id, iss_rob_id;
    logic [4:0]        count;
    logic [CDB_N-1:0]  cdb_valid;
    logic [CDB_N*RW-1:0] cdb_rob_id;
    logic [CDB_N*DW-1:0] cdb_result;
    logic [DW-1:0]     iss_V1, iss_V2, iss_pc, iss_imm;

    int checks = 0;
    int errors = 0;

    rs_sched #(
        .RS_DEPTH (DEPTH), .CDB_N (CDB_N), .DATA_W (DW), .ROB_ID_W (RW), .OPENUM_W (OW)
    ) dut (
        .clk (clk), .rst (rst), .flush (flush),
        .dsp_valid (dsp_valid), .dsp_openum (dsp_openum),
        .dsp_V1 (dsp_V1), .dsp_V2 (dsp_V2), .dsp_Q1 (dsp_Q1), .dsp_Q2 (dsp_Q2),
        .dsp_pc (dsp_pc), .dsp_imm (dsp_imm), .dsp_rob_id (dsp_rob_id),
        .full (full), .count (count),
        .cdb_valid (cdb_valid), .cdb_rob_id (cdb_rob_id), .cdb_result (cdb_result),
        .iss_valid (iss_valid), .iss_ready (iss_ready), .iss_openum (iss_openum),
        .iss_V1 (iss_V1), .iss_V2 (iss_V2), .iss_pc (iss_pc), .iss_imm (iss_imm),
        .iss_rob_id (iss_rob_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a bag of slots, each with a dispatch sequence number.
    logic          m_busy [DEPTH];
    logic [OW-1:0] m_op   [DEPTH];
    logic [DW-1:0] m_v1 [DEPTH], m_v2 [DEPTH], m_pc [DEPTH], m_imm [DEPTH];
    logic [RW-1:0] m_q1 [DEPTH], m_q2 [DEPTH], m_rob [DEPTH];
    int            m_seq  [DEPTH];
    int            seq_ctr = 0;
    logic          m_iss_valid;
    logic [OW-1:0] m_iss_op;
    logic [DW-1:0] m_iss_v1, m_iss_v2, m_iss_pc, m_iss_imm;
    logic [RW-1:0] m_iss_rob;

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_busy[i] = 1'b0; m_q1[i] = '0; m_q2[i] = '0;
        end
        m_iss_valid = 1'b0; m_iss_op = '0; m_iss_v1 = '0; m_iss_v2 = '0;
        m_iss_pc = '0; m_iss_imm = '0; m_iss_rob = '0;
    endtask

    // Look a tag up on the buses; first (lowest) matching bus supplies the value.
    task automatic resolve(inout logic [RW-1:0] q, inout logic [DW-1:0] v);
        logic [RW-1:0] tag;
        for (int k = 0; k < CDB_N; k++) begin
            tag = cdb_rob_id[k*RW +: RW];
            if (q != 0 && cdb_valid[k] && tag == q) begin
                v = cdb_result[k*DW +: DW];
                q = '0;
                break;
            end
        end
    endtask

    task automatic model_step();
        int cnt, fidx, sidx;
        if (rst || flush) begin
            model_clear();
        end else begin
            cnt = 0; fidx = -1; sidx = -1;
            for (int i = 0; i < DEPTH; i++) begin
                if (m_busy[i]) cnt++;
                else if (fidx < 0) fidx = i;
                if (m_busy[i] && m_q1[i] == 0 && m_q2[i] == 0) begin
`ifdef RS_AGE_SELECT_EN
                    if (sidx < 0 || m_seq[i] < m_seq[sidx]) sidx = i;
`else
                    if (sidx < 0) sidx = i;
`endif
                end
            end
            if (!m_iss_valid || iss_ready) begin
                if (sidx >= 0) begin
                    m_iss_valid = 1'b1; m_iss_op = m_op[sidx];
                    m_iss_v1 = m_v1[sidx]; m_iss_v2 = m_v2[sidx];
                    m_iss_pc = m_pc[sidx]; m_iss_imm = m_imm[sidx];
                    m_iss_rob = m_rob[sidx];
                    m_busy[sidx] = 1'b0;
                end else begin
                    m_iss_valid = 1'b0; m_iss_op = '0;
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (m_busy[i]) begin
                    resolve(m_q1[i], m_v1[i]);
                    resolve(m_q2[i], m_v2[i]);
                end
            end
            if (dsp_valid && cnt < DEPTH) begin
                m_busy[fidx] = 1'b1; m_op[fidx] = dsp_openum;
                m_v1[fidx] = dsp_V1; m_q1[fidx] = dsp_Q1;
                m_v2[fidx] = dsp_V2; m_q2[fidx] = dsp_Q2;
                resolve(m_q1[fidx], m_v1[fidx]);
                resolve(m_q2[fidx], m_v2[fidx]);
                m_pc[fidx] = dsp_pc; m_imm[fidx] = dsp_imm; m_rob[fidx] = dsp_rob_id;
                m_seq[fidx] = seq_ctr++;
            end
        end
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) if (m_busy[i]) c++;
        return c;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dsp(input int op, input int v1, input int v2,
                           input int q1, input int q2, input int rob);
        dsp_valid = 1'b1; dsp_openum = OW'(op);
        dsp_V1 = DW'(v1); dsp_V2 = DW'(v2);
        dsp_Q1 = RW'(q1); dsp_Q2 = RW'(q2); dsp_rob_id = RW'(rob);
        dsp_pc = $urandom; dsp_imm = $urandom;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if (iss_valid !== 1'b0 || count !== 5'd0 || full !== 1'b0) begin
            errors++;
            $display("FAIL reset_status valid=%b count=%0d full=%b want 0/0/0", iss_valid, count, full);
        end
        checks++;
        if ({iss_openum, iss_V1, iss_V2, iss_pc, iss_imm, iss_rob_id} !== '0) begin
            errors++;
            $display("FAIL reset_fields op=%0d v1=%h v2=%h pc=%h imm=%h rob=%0d want all 0",
                     iss_openum, iss_V1, iss_V2, iss_pc, iss_imm, iss_rob_id);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_issue();
        iss_ready = 1'b1;
        set_dsp(5, 3, 4, 0, 0, 1);
        tick();
        dsp_valid = 1'b0;
        checks++;
        if (count !== 5'd1) begin
            errors++; $display("FAIL basic_count_after_insert got %0d want 1", count);
        end
        tick();
        checks++;
        if (iss_valid !== 1'b1 || iss_openum !== 6'd5 || iss_V1 !== 32'd3 || iss_V2 !== 32'd4) begin
            errors++;
            $display("FAIL basic_issue valid=%b op=%0d v1=%0d v2=%0d want 1/5/3/4", iss_valid, iss_openum, iss_V1, iss_V2);
        end
        checks++;
        if (count !== 5'd0) begin
            errors++; $display("FAIL basic_count_after_issue got %0d want 0", count);
        end
    endtask

    task automatic test_wakeup();
        set_dsp(7, 0, 9, 2, 0, 6);
        tick();
        dsp_valid = 1'b0;
        cdb_valid = 2'b10; cdb_rob_id = {4'd2, 4'd0}; cdb_result = {32'h55, 32'h0};
        tick();
        cdb_valid = '0;
        checks++;
        if (iss_valid !== 1'b0) begin
            errors++; $display("FAIL wakeup_early got valid=%b want 0", iss_valid);
        end
        tick();
        checks++;
        if (iss_valid !== 1'b1 || iss_V1 !== 32'h55 || iss_V2 !== 32'd9 || iss_rob_id !== 4'd6) begin
            errors++;
            $display("FAIL wakeup_issue valid=%b v1=%h v2=%0d rob=%0d want 1/55/9/6", iss_valid, iss_V1, iss_V2, iss_rob_id);
        end
    endtask

    task automatic test_bypass();
        set_dsp(9, 1, 0, 0, 3, 8);
        cdb_valid = 2'b01; cdb_rob_id = {4'd0, 4'd3}; cdb_result = {32'h0, 32'd7};
        tick();
        dsp_valid = 1'b0; cdb_valid = '0;
        tick();
        checks++;
        if (iss_valid !== 1'b1 || iss_openum !== 6'd9 || iss_V1 !== 32'd1 || iss_V2 !== 32'd7) begin
            errors++;
            $display("FAIL bypass_issue valid=%b op=%0d v1=%0d v2=%0d want 1/9/1/7", iss_valid, iss_openum, iss_V1, iss_V2);
        end
    endtask

    task automatic test_full();
        iss_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            set_dsp(20 + i, 0, 0, (i % 15) + 1, 0, i);
            tick();
        end
        checks++;
        if (full !== 1'b1 || count !== 5'd16) begin
            errors++; $display("FAIL full_after_fill full=%b count=%0d want 1/16", full, count);
        end
        set_dsp(50, 0, 0, 0, 0, 15);
        tick();
        dsp_valid = 1'b0;
        checks++;
        if (count !== 5'd16 || iss_valid !== 1'b0) begin
            errors++; $display("FAIL full_drop count=%0d valid=%b want 16/0", count, iss_valid);
        end
        cdb_valid = 2'b01; cdb_rob_id = {4'd0, 4'd5}; cdb_result = {32'h0, 32'hAA};
        tick();
        cdb_valid = '0;
        checks++;
        if (full !== 1'b1) begin
            errors++; $display("FAIL full_held_during_wakeup got %b want 1", full);
        end
        tick();
        checks++;
        if (iss_valid !== 1'b1 || iss_rob_id !== 4'd4 || iss_V1 !== 32'hAA || full !== 1'b0 || count !== 5'd15) begin
            errors++;
            $display("FAIL full_release valid=%b rob=%0d v1=%h full=%b count=%0d want 1/4/aa/0/15",
                     iss_valid, iss_rob_id, iss_V1, full, count);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (count !== 5'd0) begin
            errors++; $display("FAIL full_cleanup count=%0d want 0", count);
        end
    endtask

    task automatic test_stall();
        int exp_order[3];
`ifdef RS_AGE_SELECT_EN
        exp_order = '{11, 12, 13};
`else
        exp_order = '{12, 11, 13};
`endif
        iss_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_dsp(10 + i, 100 + i, 200 + i, 0, 0, i + 1);
            tick();
        end
        dsp_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (iss_valid !== 1'b1 || iss_openum !== 6'd10 || iss_V1 !== 32'd100 || count !== 5'd3) begin
                errors++;
                $display("FAIL stall_hold cycle=%0d valid=%b op=%0d v1=%0d count=%0d want 1/10/100/3",
                         c, iss_valid, iss_openum, iss_V1, count);
            end
        end
        iss_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (iss_valid !== 1'b1 || iss_openum !== OW'(exp_order[i]) || iss_openum !== m_iss_op) begin
                errors++;
                $display("FAIL stall_drain_order step=%0d valid=%b op=%0d want 1/%0d",
                         i, iss_valid, iss_openum, exp_order[i]);
            end
        end
        tick();
        checks++;
        if (iss_valid !== 1'b0 || count !== 5'd0) begin
            errors++; $display("FAIL stall_drained valid=%b count=%0d want 0/0", iss_valid, count);
        end
    endtask

    task automatic test_flush();
        iss_ready = 1'b0;
        set_dsp(30, 1, 2, 0, 0, 1);
        tick();
        for (int i = 0; i < 6; i++) begin
            set_dsp(31 + i, 0, 0, 9, 0, i + 2);
            tick();
        end
        checks++;
        if (count !== 5'd6 || iss_valid !== 1'b1) begin
            errors++; $display("FAIL flush_setup count=%0d valid=%b want 6/1", count, iss_valid);
        end
        flush = 1'b1;
        set_dsp(40, 0, 0, 0, 0, 3);
        cdb_valid = 2'b01; cdb_rob_id = {4'd0, 4'd9}; cdb_result = '0;
        tick();
        flush = 1'b0; dsp_valid = 1'b0; cdb_valid = '0;
        checks++;
        if (count !== 5'd0 || iss_valid !== 1'b0 || full !== 1'b0 || iss_openum !== 6'd0) begin
            errors++;
            $display("FAIL flush_clear count=%0d valid=%b full=%b op=%0d want 0/0/0/0", count, iss_valid, full, iss_openum);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 2000; c++) begin
            dsp_valid  = ($urandom_range(0, 9) < 6);
            dsp_openum = OW'($urandom_range(1, 63));
            dsp_V1 = $urandom; dsp_V2 = $urandom; dsp_pc = $urandom; dsp_imm = $urandom;
            dsp_Q1 = $urandom_range(0, 1) ? RW'($urandom_range(1, 15)) : '0;
            dsp_Q2 = $urandom_range(0, 2) == 0 ? RW'($urandom_range(1, 15)) : '0;
            dsp_rob_id = RW'($urandom);
            cdb_valid  = CDB_N'($urandom);
            cdb_rob_id = CDB_N*RW'($urandom);
            cdb_result = {$urandom, $urandom};
            iss_ready  = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 63) == 0);
            tick();
            checks++;
            if (count !== 5'(model_count())) begin
                errors++; $display("FAIL rand_count cycle=%0d got %0d want %0d", c, count, model_count());
            end
            checks++;
            if (full !== (model_count() == DEPTH)) begin
                errors++; $display("FAIL rand_full cycle=%0d got %b want %b", c, full, model_count() == DEPTH);
            end
            checks++;
            if (iss_valid !== m_iss_valid || iss_openum !== m_iss_op) begin
                errors++;
                $display("FAIL rand_issue cycle=%0d valid=%b op=%0d want %b/%0d", c, iss_valid, iss_openum, m_iss_valid, m_iss_op);
            end
            if (m_iss_valid) begin
                checks++;
                if ({iss_V1, iss_V2, iss_pc, iss_imm, iss_rob_id} !== {m_iss_v1, m_iss_v2, m_iss_pc, m_iss_imm, m_iss_rob}) begin
                    errors++;
                    $display("FAIL rand_fields cycle=%0d v1=%h v2=%h pc=%h imm=%h rob=%0d want %h %h %h %h %0d",
                             c, iss_V1, iss_V2, iss_pc, iss_imm, iss_rob_id,
                             m_iss_v1, m_iss_v2, m_iss_pc, m_iss_imm, m_iss_rob);
                end
            end
        end
        dsp_valid = 1'b0; cdb_valid = '0; flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; dsp_valid = 1'b0; dsp_openum = '0;
        dsp_V1 = '0; dsp_V2 = '0; dsp_Q1 = '0; dsp_Q2 = '0; dsp_pc = '0; dsp_imm = '0;
        dsp_rob_id = '0; cdb_valid = '0; cdb_rob_id = '0; cdb_result = '0; iss_ready = 1'b0;
        model_clear();
        test_reset();
        test_basic_issue();
        test_wakeup();
        test_bypass();
        test_full();
        test_stall();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rs_sched.md
# rs_sched

Parametrised reservation station for the out-of-order core's ALU/branch path. It sits between the dispatcher and the execution unit. It holds up to RS_DEPTH waiting instructions and snoops CDB_N result buses to resolve operand tags. Each cycle it issues at most one ready instruction through a registered valid/ready port that honours execution-unit backpressure.

## Interface
- RS_DEPTH, 16: entry count (power of two, ≥2)
- CDB_N, 2: number of broadcast result buses snooped
- DATA_W, 32: operand/pc/imm width
- ROB_ID_W, 4: ROB tag width; tag 0 reserved as "value ready"
- OPENUM_W, 6: opcode-enum width; value 0 = NOP
- clk  in  1  clock; one clock domain
- rst  in  1  synchronous, active-high reset
- flush  in  1  commit-time mispredict; clears all state
- dsp_valid  in  1  dispatch request
- dsp_openum  in  OPENUM_W  opcode enum
- dsp_V1, dsp_V2  in  DATA_W  operand values, valid when the matching Q is 0
- dsp_Q1, dsp_Q2  in  ROB_ID_W  producer tags
- dsp_pc, dsp_imm  in  DATA_W  pc and immediate
- dsp_rob_id  in  ROB_ID_W  destination ROB tag
- full  out  1  no free entry
- count  out  $clog2(RS_DEPTH+1)  occupied entries
- cdb_valid  in  CDB_N  per-bus valid
- cdb_rob_id  in  CDB_N*ROB_ID_W  tags; bus k is at slice [k*ROB_ID_W +: ROB_ID_W]
- cdb_result  in  CDB_N*DATA_W  results, same slicing
- iss_valid  out  1  issue register holds an instruction
- iss_ready  in  1  execution unit accepts this cycle
- iss_openum, iss_V1, iss_V2, iss_pc, iss_imm, iss_rob_id  out  issued fields, widths as the matching dsp_* fields

## Operation
- Entry state: busy, openum, V1, V2, Q1, Q2, pc, imm, rob_id, plus age ordering. An entry is ready when busy && Q1==0 && Q2==0.
- Insert:
  - When dsp_valid && !full, write to the lowest-index free entry.
  - Dispatch while full is dropped. Upstream must not issue it.
  - Same-cycle bypass: if a valid CDB bus tag equals a nonzero dsp_Qx, store Qx=0 and Vx=that result.
- Wakeup: for every busy entry and every bus k with cdb_valid[k] and a nonzero tag equal to Qx, set Vx=result and Qx=0 next cycle. If several buses match, the lowest k wins; this is a protocol error.
- Select/issue:
  - The issue register loads when !iss_valid || iss_ready.
  - If a ready entry exists, load the selected entry, set iss_valid=1 and clear that entry's busy.
  - Otherwise set iss_valid=0 and iss_openum=0.
  - While the register is stalled (iss_valid && !iss_ready), its contents are held and no entry is freed.
- count = popcount(busy), combinational from registered state. full = (count == RS_DEPTH).
- Flush and rst have identical effect: all busy, Q and issue fields cleared; iss_valid=0. They take priority over simultaneous insert, wakeup and issue.

## Timing
- Reset values: iss_valid 0, all iss_* fields 0, full 0, count 0.
- Wakeup latency:
  - CDB broadcast in cycle t updates the entry's Q at edge t+1.
  - The entry can be selected in t+1 and appears on iss_* after edge t+2.
  - An instruction inserted at edge t can appear on iss_* after edge t+1 at the earliest.
- Insert and issue in the same cycle:
  - The free slot is computed from pre-edge state, so a slot freed by issue is reusable the next cycle.
  - full does not drop until after the edge.
- Insert, wakeup and issue of different entries in one cycle are all committed. A wakeup on the entry being issued is discarded.
- count may change by −1, 0 or +1 per cycle.

## Configuration
- RS_AGE_SELECT_EN defined:
  - Select the oldest ready entry in dispatch order, tracked by an RS_DEPTH×RS_DEPTH age matrix updated on insert.
  - Ties are impossible.
- Not defined:
  - Select the lowest-index ready entry; no age matrix is built.
  - Starvation is possible and accepted.

## Structure
- Shared package/defines: OPENUM_NOP = 0, ZERO_ROB = 0, and the CDB slice convention.
- One sub-module, rs_sched_select: a combinational priority/age picker taking busy, ready and age inputs and producing the free index, the select index and their valid flags.

## Test plan
- Insert opcode 5 with Q1=Q2=0, V1=3, V2=4, iss_ready=1 → after one edge: iss_valid=1, V1=3, V2=4; count returns to 0.
- Insert with Q1=2, then broadcast bus 1 with tag 2 and result 0x55 → issue two edges after the broadcast with V1=0x55.
- Insert with Q2=3 while bus 0 carries tag 3 and result 7 in the same cycle → stored ready; issued next edge with V2=7.
- Fill 16 entries with unresolved tags → full=1, count=16. A 17th dispatch is dropped. Resolve one tag → that entry issues, and full falls the cycle after.
- Hold iss_ready=0 for 5 cycles with 3 ready entries → iss_* held constant and count stays 3.
  - With RS_AGE_SELECT_EN: entries issue in dispatch order despite reversed indices.
- Assert flush with 6 busy entries and iss_valid=1 → next edge: count=0, iss_valid=0, full=0.
